mem_access_unit: RTL and testbench
==================================

MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 The block SHALL have parameter BIG_ENDIAN, default 1, selecting byte-lane order (1: byte offset 0 in bits [31:24]; 0: byte offset 0 in bits [7:0]).
REQ-002 The block SHALL have port clock, input, 1, the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-004 The block SHALL have port req_valid_in, input, 1, processor request present.
REQ-005 The block SHALL have port req_ready_out, output, 1, block can accept a request.
REQ-006 The block SHALL have port req_we_in, input, 1, 1 = store, 0 = load.
REQ-007 The block SHALL have port req_size_in, input, 2, access size: 00 byte, 01 halfword, 11 word, 10 reserved.
REQ-008 The block SHALL have port req_signed_in, input, 1, sign-extend sub-word loads.
REQ-009 The block SHALL have port req_addr_in, input, 32, byte address.
REQ-010 The block SHALL have port req_wdata_in, input, 32, store data, right-justified.
REQ-011 The block SHALL have port resp_valid_out, output, 1, one-cycle completion pulse.
REQ-012 The block SHALL have port resp_rdata_out, output, 32, load result, extended to 32 bits.
REQ-013 The block SHALL have port resp_misaligned_out, output, 1, request rejected, qualified by resp_valid_out.
REQ-014 The block SHALL have ports mem_addr_out (output, 32), mem_writedata_out (output, 32), mem_re_out (output, 1), mem_we_out (output, 1), mem_size_out (output, 2) and mem_readdata_in (input, 32), forming the data-memory port (combinational read, write on clock edge).

Function
REQ-015 The block SHALL implement states IDLE, READ, WRITE and RESP; req_ready_out = 1 only in IDLE.
REQ-016 In IDLE, a handshake (req_valid_in & req_ready_out) SHALL register we, size, signed, addr and wdata; otherwise the block SHALL stay in IDLE.
REQ-017 A request SHALL be misaligned when size = 10, size = 01 with addr[0] = 1, or size = 11 with addr[1:0] != 0.
REQ-018 A misaligned request SHALL transition IDLE->RESP with no mem_re/mem_we, then assert resp_misaligned_out = 1 and resp_rdata_out = 0.
REQ-019 Aligned loads and sub-word stores SHALL transition IDLE->READ; word stores SHALL transition IDLE->WRITE.
REQ-020 In READ the block SHALL drive mem_re_out = 1 and capture mem_readdata_in at the clock edge; loads then go to RESP, sub-word stores to WRITE.
REQ-021 In WRITE the block SHALL drive mem_we_out = 1 for exactly one cycle, then go to RESP.
REQ-022 Sub-word store data SHALL replace only the addressed lane(s) of the captured word, preserving all other bits; word store data SHALL be req_wdata unchanged.
REQ-023 Loads SHALL extract the addressed lane(s) per BIG_ENDIAN, then zero-extend (signed = 0) or sign-extend (signed = 1); word loads SHALL ignore signed.
REQ-024 mem_addr_out SHALL be {addr[31:2], 2'b00} in READ and WRITE and 0 otherwise; mem_size_out SHALL be 2'b11 always; mem_writedata_out SHALL be 0 outside WRITE.
REQ-025 RESP SHALL last one cycle with resp_valid_out = 1, then return to IDLE; resp_rdata_out SHALL hold its value until the next RESP, and stores SHALL leave it unchanged.
REQ-026 Latency from the handshake cycle T to the resp_valid_out cycle SHALL be: misaligned T+1; load T+2; word store T+2; sub-word store T+3.
REQ-027 mem_re_out and mem_we_out SHALL never both be 1, and no memory access SHALL occur outside READ/WRITE.
REQ-028 Inputs SHALL be ignored outside IDLE; request fields SHALL be used only from the registered copy.

Reset
REQ-029 While reset = 1 the block SHALL be in IDLE with req_ready_out = 1 and resp_valid_out, resp_rdata_out, resp_misaligned_out, mem_re_out, mem_we_out and mem_addr_out all 0.
REQ-030 Reset asserted in any state SHALL immediately abort the operation and suppress any pending or in-progress mem_we_out, with no response issued.

Verification
REQ-031 Memory word 0x10000004 = 0x80FF7F01, BIG_ENDIAN = 1, signed lb from 0x10000004 -> mem_re in T+1 at 0x10000004, resp_valid in T+2, rdata 0xFFFFFF80.
REQ-032 Same memory, lhu from 0x10000006 -> rdata 0x00007F01; lh from 0x10000004 -> rdata 0xFFFF80FF.
REQ-033 sb with wdata 0x000000AA to 0x10000005 -> READ in T+1, single mem_we in T+2 with writedata 0x80AA7F01, resp in T+3.
REQ-034 sw of 0x12345678 to 0x7FFFFFFC -> no mem_re, mem_we in T+1 at 0x7FFFFFFC with data 0x12345678, resp in T+2.
REQ-035 lw from 0x10000002 -> no memory access, resp_valid in T+1, resp_misaligned_out = 1, rdata 0.
REQ-036 Reset asserted in the READ cycle of an sh -> mem_we never asserts, no resp_valid, req_ready_out = 1 during and after reset.

Source files
------------

// File: rtl/mem_access_unit.sv
// Load/store unit between a processor and a word-wide data memory: checks alignment,
// extracts and extends load lanes, and merges sub-word stores by read-modify-write.
module mem_access_unit #(
    parameter bit BIG_ENDIAN = 1'b1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        req_valid_in,
    output logic        req_ready_out,
    input  logic        req_we_in,
    input  logic [1:0]  req_size_in,
    input  logic        req_signed_in,
    input  logic [31:0] req_addr_in,
    input  logic [31:0] req_wdata_in,
    output logic        resp_valid_out,
    output logic [31:0] resp_rdata_out,
    output logic        resp_misaligned_out,
    output logic [31:0] mem_addr_out,
    output logic [31:0] mem_writedata_out,
    output logic        mem_re_out,
    output logic        mem_we_out,
    output logic [1:0]  mem_size_out,
    input  logic [31:0] mem_readdata_in
);

    // Request handshake: a request is taken on a rising edge where
    // req_valid_in && req_ready_out; req_ready_out is high only in IDLE.
    typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} state_t;

    state_t      state;
    logic        we_q;
    logic        signed_q;
    logic        mis_q;
    logic [1:0]  size_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [31:0] wr_data_q;

    logic        req_mis;
    logic [4:0]  lane_shift;
    logic [31:0] lane_mask;
    logic [31:0] shifted;
    logic [31:0] load_ext;
    logic [31:0] merged;

    always_comb begin
        req_mis = 1'b0;
        case (req_size_in)
            2'b10:   req_mis = 1'b1;
            2'b01:   req_mis = req_addr_in[0];
            2'b11:   req_mis = |req_addr_in[1:0];
            default: req_mis = 1'b0;
        endcase
    end

    // Bit position of the addressed lane inside the memory word.
    always_comb begin
        lane_shift = 5'd0;
        lane_mask  = 32'hFFFF_FFFF;
        case (size_q)
            2'b00: begin
                lane_mask  = 32'h0000_00FF;
                lane_shift = BIG_ENDIAN ? {~addr_q[1:0], 3'b000} : {addr_q[1:0], 3'b000};
            end
            2'b01: begin
                lane_mask  = 32'h0000_FFFF;
                lane_shift = BIG_ENDIAN ? {~addr_q[1], 4'b0000} : {addr_q[1], 4'b0000};
            end
            default: begin
                lane_mask  = 32'hFFFF_FFFF;
                lane_shift = 5'd0;
            end
        endcase
    end

    always_comb begin
        shifted = mem_readdata_in >> lane_shift;
        case (size_q)
            2'b00:   load_ext = {{24{signed_q & shifted[7]}}, shifted[7:0]};
            2'b01:   load_ext = {{16{signed_q & shifted[15]}}, shifted[15:0]};
            default: load_ext = shifted;
        endcase
        merged = (mem_readdata_in & ~(lane_mask << lane_shift))
               | ((wdata_q & lane_mask) << lane_shift);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state          <= IDLE;
            we_q           <= 1'b0;
            signed_q       <= 1'b0;
            mis_q          <= 1'b0;
            size_q         <= 2'b00;
            addr_q         <= 32'h0;
            wdata_q        <= 32'h0;
            wr_data_q      <= 32'h0;
            resp_rdata_out <= 32'h0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid_in) begin
                        we_q     <= req_we_in;
                        size_q   <= req_size_in;
                        signed_q <= req_signed_in;
                        addr_q   <= req_addr_in;
                        wdata_q  <= req_wdata_in;
                        mis_q    <= req_mis;
                        if (req_mis) begin
                            resp_rdata_out <= 32'h0;
                            state          <= RESP;
                        end else if (req_we_in && req_size_in == 2'b11) begin
                            wr_data_q <= req_wdata_in;
                            state     <= WRITE;
                        end else begin
                            state <= READ;
                        end
                    end
                end
                READ: begin
                    if (we_q) begin
                        wr_data_q <= merged;
                        state     <= WRITE;
                    end else begin
                        resp_rdata_out <= load_ext;
                        state          <= RESP;
                    end
                end
                WRITE:   state <= RESP;
                RESP:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Memory-side and response outputs are pure decodes of the registered state.
    assign req_ready_out       = (state == IDLE);
    assign mem_re_out          = (state == READ);
    assign mem_we_out          = (state == WRITE);
    assign mem_addr_out        = (state == READ || state == WRITE) ? {addr_q[31:2], 2'b00} : 32'h0;
    assign mem_writedata_out   = (state == WRITE) ? wr_data_q : 32'h0;
    assign mem_size_out        = 2'b11;
    assign resp_valid_out      = (state == RESP);
    assign resp_misaligned_out = (state == RESP) && mis_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Randomized bench for mem_access_unit: a byte-addressed reference memory predicts
// every cycle of each transaction, checked against the DUT on each falling edge.
module tb_mem_access_unit;

    localparam bit BIG_ENDIAN = 1'b1;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        req_valid_in = 1'b0;
    logic        req_ready_out;
    logic        req_we_in = 1'b0;
    logic [1:0]  req_size_in = 2'b00;
    logic        req_signed_in = 1'b0;
    logic [31:0] req_addr_in = 32'h0;
    logic [31:0] req_wdata_in = 32'h0;
    logic        resp_valid_out;
    logic [31:0] resp_rdata_out;
    logic        resp_misaligned_out;
    logic [31:0] mem_addr_out;
    logic [31:0] mem_writedata_out;
    logic        mem_re_out;
    logic        mem_we_out;
    logic [1:0]  mem_size_out;
    logic [31:0] mem_readdata_in = 32'h0;

    mem_access_unit #(.BIG_ENDIAN(BIG_ENDIAN)) dut (
        .clock               (clock),
        .reset               (reset),
        .req_valid_in        (req_valid_in),
        .req_ready_out       (req_ready_out),
        .req_we_in           (req_we_in),
        .req_size_in         (req_size_in),
        .req_signed_in       (req_signed_in),
        .req_addr_in         (req_addr_in),
        .req_wdata_in        (req_wdata_in),
        .resp_valid_out      (resp_valid_out),
        .resp_rdata_out      (resp_rdata_out),
        .resp_misaligned_out (resp_misaligned_out),
        .mem_addr_out        (mem_addr_out),
        .mem_writedata_out   (mem_writedata_out),
        .mem_re_out          (mem_re_out),
        .mem_we_out          (mem_we_out),
        .mem_size_out        (mem_size_out),
        .mem_readdata_in     (mem_readdata_in)
    );

    // ---------------- clock ----------------
    always #5 clock = ~clock;

    // ---------------- scoreboard state ----------------
    typedef struct packed {
        logic        ready;
        logic        re;
        logic        we;
        logic        rvalid;
        logic        mis;
        logic [1:0]  size;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
    } obs_t;
    localparam int OBS_W = $bits(obs_t);

    logic [OBS_W-1:0] exp_q[$];
    int          n_cmp = 0;
    int          n_fail = 0;
    bit          check_en = 1'b0;
    logic [31:0] last_rdata = 32'h0;
    logic [7:0]  ref_bytes[int unsigned];
    logic [7:0]  env_bytes[int unsigned];
    logic [31:0] got_rdata = 32'h0;
    logic        got_mis = 1'b0;
    logic [31:0] got_wdata = 32'h0;
    logic [31:0] got_waddr = 32'h0;
    int          wr_count = 0;
    int          resp_count = 0;
    int          env_tick = 0;

    // ---------------- byte-level memories ----------------
    function automatic logic [7:0] init_byte(input logic [31:0] a);
        return 8'(a[7:0] * 8'd37 + a[15:8] + 8'h5A);
    endfunction

    function automatic logic [7:0] ref_get(input logic [31:0] a);
        return ref_bytes.exists(a) ? ref_bytes[a] : init_byte(a);
    endfunction

    function automatic logic [7:0] env_get(input logic [31:0] a);
        return env_bytes.exists(a) ? env_bytes[a] : init_byte(a);
    endfunction

    // n bytes starting at a, most significant first when big-endian.
    function automatic logic [31:0] ref_read(input logic [31:0] a, input int n);
        logic [31:0] v = 32'h0;
        for (int i = 0; i < n; i++) begin
            if (BIG_ENDIAN) v = (v << 8) | 32'(ref_get(32'(a + i)));
            else            v = v | (32'(ref_get(32'(a + i))) << (8 * i));
        end
        return v;
    endfunction

    function automatic logic [31:0] env_read(input logic [31:0] a, input int n);
        logic [31:0] v = 32'h0;
        for (int i = 0; i < n; i++) begin
            if (BIG_ENDIAN) v = (v << 8) | 32'(env_get(32'(a + i)));
            else            v = v | (32'(env_get(32'(a + i))) << (8 * i));
        end
        return v;
    endfunction

    task automatic ref_write(input logic [31:0] a, input int n, input logic [31:0] d);
        for (int i = 0; i < n; i++) begin
            if (BIG_ENDIAN) ref_bytes[32'(a + i)] = 8'(d >> (8 * (n - 1 - i)));
            else            ref_bytes[32'(a + i)] = 8'(d >> (8 * i));
        end
    endtask

    task automatic env_write(input logic [31:0] a, input int n, input logic [31:0] d);
        for (int i = 0; i < n; i++) begin
            if (BIG_ENDIAN) env_bytes[32'(a + i)] = 8'(d >> (8 * (n - 1 - i)));
            else            env_bytes[32'(a + i)] = 8'(d >> (8 * i));
        end
    endtask

    // Memory environment: combinational read only meaningful while mem_re_out is high.
    always @(mem_addr_out or mem_re_out or env_tick)
        mem_readdata_in = mem_re_out ? env_read(mem_addr_out, 4) : $urandom;

    always @(negedge clock) begin
        if (!reset && mem_we_out) begin
            env_write(mem_addr_out, 4, mem_writedata_out);
            got_wdata = mem_writedata_out;
            got_waddr = mem_addr_out;
            wr_count++;
            env_tick++;
        end
    end

    // ---------------- reference model ----------------
    function automatic obs_t idle_obs(input logic [31:0] rd);
        obs_t o = '0;
        o.ready = 1'b1;
        o.size  = 2'b11;
        o.rdata = rd;
        return o;
    endfunction

    task automatic model_push(input logic we, input logic [1:0] size, input logic sgn,
                              input logic [31:0] addr, input logic [31:0] wdata);
        obs_t        c;
        int          n;
        logic [31:0] wa;
        logic [31:0] v;
        bit          mis;
        n   = (size == 2'b00) ? 1 : (size == 2'b01) ? 2 : 4;
        wa  = addr & 32'hFFFF_FFFC;
        mis = (size == 2'b10) || (addr % n != 0);
        c = '0;
        c.size  = 2'b11;
        c.rdata = last_rdata;
        if (mis) begin
            c.rvalid = 1'b1; c.mis = 1'b1; c.rdata = 32'h0;
            exp_q.push_back(c);
            last_rdata = 32'h0;
        end else if (!we) begin
            v = ref_read(addr, n);
            if (sgn && n < 4 && longint'(v) >= (64'd1 << (8 * n - 1)))
                v = 32'(longint'(v) - (64'd1 << (8 * n)));
            c.re = 1'b1; c.addr = wa;
            exp_q.push_back(c);
            c = '0; c.size = 2'b11; c.rvalid = 1'b1; c.rdata = v;
            exp_q.push_back(c);
            last_rdata = v;
        end else begin
            ref_write(addr, n, wdata);
            if (n < 4) begin
                c.re = 1'b1; c.addr = wa;
                exp_q.push_back(c);
                c.re = 1'b0;
            end
            c.we = 1'b1; c.addr = wa; c.wdata = ref_read(wa, 4);
            exp_q.push_back(c);
            c.we = 1'b0; c.addr = 32'h0; c.wdata = 32'h0; c.rvalid = 1'b1;
            exp_q.push_back(c);
        end
    endtask

    // ---------------- per-cycle compare ----------------
    always @(negedge clock) begin
        obs_t e;
        obs_t a;
        if (check_en) begin
            e = (exp_q.size() > 0) ? obs_t'(exp_q.pop_front()) : idle_obs(last_rdata);
            a.ready = req_ready_out;  a.re = mem_re_out;  a.we = mem_we_out;
            a.rvalid = resp_valid_out; a.mis = resp_misaligned_out; a.size = mem_size_out;
            a.addr = mem_addr_out;    a.wdata = mem_writedata_out; a.rdata = resp_rdata_out;
            n_cmp++;
            if (a !== e) begin
                n_fail++;
                $display("FAIL outputs @%0t actual rdy=%b re=%b we=%b vld=%b mis=%b sz=%b addr=%h wd=%h rd=%h required rdy=%b re=%b we=%b vld=%b mis=%b sz=%b addr=%h wd=%h rd=%h",
                         $time, a.ready, a.re, a.we, a.rvalid, a.mis, a.size, a.addr, a.wdata, a.rdata,
                         e.ready, e.re, e.we, e.rvalid, e.mis, e.size, e.addr, e.wdata, e.rdata);
            end
            if (resp_valid_out) begin
                got_rdata = resp_rdata_out;
                got_mis   = resp_misaligned_out;
                resp_count++;
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    task automatic junk_fields();
        req_we_in     = 1'($urandom_range(0, 1));
        req_size_in   = 2'($urandom_range(0, 3));
        req_signed_in = 1'($urandom_range(0, 1));
        req_addr_in   = $urandom;
        req_wdata_in  = $urandom;
    endtask

    // Entered just after a rising edge with the DUT idle; returns the same way.
    task automatic do_req(input logic we, input logic [1:0] size, input logic sgn,
                          input logic [31:0] addr, input logic [31:0] wdata);
        int guard;
        req_valid_in  = 1'b1;
        req_we_in     = we;
        req_size_in   = size;
        req_signed_in = sgn;
        req_addr_in   = addr;
        req_wdata_in  = wdata;
        @(posedge clock); #1;
        model_push(we, size, sgn, addr, wdata);
        guard = 0;
        while (exp_q.size() > 0 && guard < 10) begin
            req_valid_in = 1'($urandom_range(0, 1));
            junk_fields();
            @(posedge clock); #1;
            guard++;
        end
        if (exp_q.size() > 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL timeout actual=%0d pending cycles required=0", exp_q.size());
            exp_q.delete();
        end
        req_valid_in = 1'b0;
        junk_fields();
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int wr_before;
        int resp_before;
        logic [31:0] addr;

        ref_write(32'h1000_0004, 4, 32'h80FF_7F01);
        env_write(32'h1000_0004, 4, 32'h80FF_7F01);

        // Reset state, with a request pending on the inputs.
        req_valid_in = 1'b1;
        #1 reset = 1'b1;
        repeat (2) begin
            @(negedge clock);
            check32("reset_outputs",
                    {31'h0, req_ready_out} << 8 | {mem_re_out, mem_we_out, resp_valid_out, resp_misaligned_out, 4'h0},
                    32'h0000_0100);
            check32("reset_rdata", resp_rdata_out, 32'h0);
            check32("reset_addr", mem_addr_out, 32'h0);
        end
        reset = 1'b0;
        req_valid_in = 1'b0;
        @(posedge clock); #1;
        check_en = 1'b1;

        // Directed: lb / lhu / lh on word 0x80FF7F01.
        do_req(1'b0, 2'b00, 1'b1, 32'h1000_0004, 32'h0);
        check32("lb_signed", got_rdata, 32'hFFFF_FF80);
        do_req(1'b0, 2'b01, 1'b0, 32'h1000_0006, 32'h0);
        check32("lhu", got_rdata, 32'h0000_7F01);
        do_req(1'b0, 2'b01, 1'b1, 32'h1000_0004, 32'h0);
        check32("lh_signed", got_rdata, 32'hFFFF_80FF);

        // Directed: sb merge, then word store at the top of the address range.
        wr_before = wr_count;
        do_req(1'b1, 2'b00, 1'b0, 32'h1000_0005, 32'h0000_00AA);
        check32("sb_writedata", got_wdata, 32'h80AA_7F01);
        check32("sb_write_count", 32'(wr_count - wr_before), 32'd1);
        check32("sb_rdata_kept", resp_rdata_out, 32'hFFFF_80FF);
        do_req(1'b1, 2'b11, 1'b0, 32'h7FFF_FFFC, 32'h1234_5678);
        check32("sw_writedata", got_wdata, 32'h1234_5678);
        check32("sw_writeaddr", got_waddr, 32'h7FFF_FFFC);

        // Directed: misaligned word load.
        wr_before = wr_count;
        do_req(1'b0, 2'b11, 1'b0, 32'h1000_0002, 32'h0);
        check32("lw_misaligned_flag", 32'(got_mis), 32'd1);
        check32("lw_misaligned_rdata", got_rdata, 32'h0);
        check32("lw_misaligned_nowrite", 32'(wr_count - wr_before), 32'd0);

        // Reset during the READ cycle of an sh.
        wr_before   = wr_count;
        resp_before = resp_count;
        req_valid_in = 1'b1; req_we_in = 1'b1; req_size_in = 2'b01;
        req_signed_in = 1'b0; req_addr_in = 32'h1000_0002; req_wdata_in = 32'h0000_BEEF;
        @(posedge clock); #1;
        check_en = 1'b0;
        req_valid_in = 1'b0;
        #2;
        check32("sh_in_read", 32'(mem_re_out), 32'd1);
        reset = 1'b1;
        #1;
        check32("abort_ready", 32'(req_ready_out), 32'd1);
        check32("abort_mem", {30'h0, mem_re_out, mem_we_out}, 32'h0);
        check32("abort_resp", {30'h0, resp_valid_out, resp_misaligned_out}, 32'h0);
        check32("abort_rdata", resp_rdata_out, 32'h0);
        check32("abort_addr", mem_addr_out, 32'h0);
        repeat (2) begin
            @(negedge clock);
            check32("reset_hold", {29'h0, req_ready_out, mem_we_out, resp_valid_out}, 32'h4);
        end
        reset = 1'b0;
        last_rdata = 32'h0;
        @(posedge clock); #1;
        check_en = 1'b1;
        repeat (3) begin
            @(posedge clock); #1;
        end
        check32("abort_no_write", 32'(wr_count - wr_before), 32'd0);
        check32("abort_no_resp", 32'(resp_count - resp_before), 32'd0);

        // Randomized traffic over two small regions so stores feed later loads.
        for (int k = 0; k < 300; k++) begin
            if ($urandom_range(0, 3) == 0) addr = 32'h7FFF_FFF0 + $urandom_range(0, 15);
            else                           addr = 32'h1000_0000 + $urandom_range(0, 31);
            do_req(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                   1'($urandom_range(0, 1)), addr, $urandom);
            repeat ($urandom_range(0, 2)) begin
                @(posedge clock); #1;
            end
        end

        @(posedge clock); #1;
        check_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
